// File: rtl/spi_link_pkg.sv
// Shared definitions for the frame-based SPI link: FSM states, frame widths and the
// bit layout of the pulse-width and switch/k words carried over it.
package spi_link_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StShift,
        StTrail,
        StGap
    } spi_state_e;

    localparam int unsigned SPI1_FRAME_W = 96;
    localparam int unsigned SPI2_FRAME_W = 16;

    // 96-bit channel: eight 12-bit pulse widths, field i at [12*i+11 : 12*i]
    localparam int unsigned PW_W     = 12;
    localparam int unsigned PW_COUNT = SPI1_FRAME_W / PW_W;

    // 16-bit channel: switch mask in [7:0], k in [10:8]
    localparam int unsigned SW_MASK_LSB = 0;
    localparam int unsigned SW_MASK_W   = 8;
    localparam int unsigned K_LSB       = 8;
    localparam int unsigned K_W         = 3;

    function automatic int unsigned pw_lsb(input int unsigned idx);
        return PW_W * idx;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_bit_timer.sv
// Loadable down-counter pacing every SPI link phase; o_tc flags the last cycle of a phase.
module spi_bit_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Loaded with (length - 1) so a phase of n cycles ends when the count reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/spi_frame_master.sv
// Frame-based SPI initiator: shifts one FRAME_W-bit word out on MOSI (MSB first) while
// capturing MISO, with slave-select lead, trail and inter-frame gap timing.
module spi_frame_master
    import spi_link_pkg::*;
#(
    parameter int unsigned FRAME_W   = 96,
    parameter int unsigned DIV       = 4,
    parameter int unsigned LEAD_CYC  = 2,
    parameter int unsigned TRAIL_CYC = 2,
    parameter int unsigned GAP_CYC   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [FRAME_W-1:0] i_tx_data,
    output logic [FRAME_W-1:0] o_rx_data,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_ss,
    output logic               o_mosi,
    input  logic               i_miso
);

    localparam int unsigned CNT_W = $clog2(max4(DIV, LEAD_CYC, TRAIL_CYC, GAP_CYC) + 1);
    localparam int unsigned BIT_W = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] LEAD_LD  = CNT_W'(LEAD_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LD   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] TRAIL_LD = CNT_W'(TRAIL_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

    spi_state_e         r_state;
    logic [FRAME_W-2:0] r_tx;
    logic [FRAME_W-1:0] r_rx;
    logic [FRAME_W-1:0] r_rx_data;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_ss;
    logic               r_mosi;

    logic               w_tc;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic               w_abort_hit;
    logic               w_last_bit;

    assign w_abort_hit = i_abort && (r_state inside {StLead, StShift, StTrail});
    assign w_last_bit  = (r_bit_cnt == BIT_W'(1));

    spi_bit_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .o_tc      (w_tc)
    );

    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        if (w_abort_hit) begin
            w_load     = 1'b1;
            w_load_val = GAP_LD;
        end else begin
            case (r_state)
                StIdle: begin
                    w_load     = i_start;
                    w_load_val = LEAD_LD;
                end
                StLead: begin
                    w_load     = w_tc;
                    w_load_val = DIV_LD;
                end
                StShift: begin
                    w_load     = w_tc;
                    w_load_val = w_last_bit ? TRAIL_LD : DIV_LD;
                end
                StTrail: begin
                    w_load     = w_tc;
                    w_load_val = GAP_LD;
                end
                default: ;
            endcase
        end
    end

    // MSB goes straight to MOSI at start; r_tx holds the remaining bits, next one on top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StIdle;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_bit_cnt <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ss      <= 1'b1;
            r_mosi    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort_hit) begin
                r_state   <= StGap;
                r_ss      <= 1'b1;
                r_mosi    <= 1'b0;
                r_bit_cnt <= '0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        if (i_start) begin
                            r_state <= StLead;
                            r_tx    <= i_tx_data[FRAME_W-2:0];
                            r_rx    <= '0;
                            r_busy  <= 1'b1;
                            r_ss    <= 1'b0;
                            r_mosi  <= i_tx_data[FRAME_W-1];
                        end
                    end
                    StLead: begin
                        if (w_tc) begin
                            r_state   <= StShift;
                            r_bit_cnt <= BIT_W'(FRAME_W);
                        end
                    end
                    StShift: begin
                        if (w_tc) begin
                            r_rx      <= {r_rx[FRAME_W-2:0], i_miso};
                            r_tx      <= {r_tx[FRAME_W-3:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt - BIT_W'(1);
                            if (w_last_bit) begin
                                r_state <= StTrail;
                                r_mosi  <= 1'b0;
                            end else begin
                                r_mosi  <= r_tx[FRAME_W-2];
                            end
                        end
                    end
                    StTrail: begin
                        if (w_tc) begin
                            r_state   <= StGap;
                            r_ss      <= 1'b1;
                            r_done    <= 1'b1;
                            r_rx_data <= r_rx;
                        end
                    end
                    StGap: begin
                        if (w_tc) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

    assign o_rx_data = r_rx_data;
    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_ss      = r_ss;
    assign o_mosi    = r_mosi;

endmodule

// File: tb/tb_spi_frame_master.sv
// Bench for spi_frame_master: a 16-bit/DIV=4 instance and a 96-bit/DIV=1 instance, random
// frames scored against a frame-level reference model by a negedge monitor.
module tb_spi_frame_master;
    import spi_link_pkg::*;

    localparam int LEAD  = 2;
    localparam int TRAIL = 2;
    localparam int GAP   = 4;
    localparam int DIV16 = 4;
    localparam int DIV96 = 1;
    localparam int LIMIT = 1000;

    typedef struct {
        logic [95:0] tx;
        logic [95:0] rx;
        int          len;
        bit          aborted;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        start16 = 1'b0, abort16 = 1'b0;
    logic [15:0] tx16 = '0;
    logic [15:0] rx16;
    logic        busy16, done16, ss16, mosi16, miso16;

    logic        start96 = 1'b0, abort96 = 1'b0;
    logic [95:0] tx96 = '0;
    logic [95:0] rx96;
    logic        busy96, done96, ss96, mosi96, miso96;

    // Slave models: 16-bit side is either 1-clk-delayed loopback or a pattern driver.
    int          cyc16 = 0;
    logic        mosi_d1 = 1'b0;
    logic        sel_slave16 = 1'b0;
    logic [15:0] slave_pat16 = '0;
    logic        slave_bit16;

    frame_t      q0[$];
    frame_t      q1[$];
    int          n_total = 0;
    int          n_pass = 0;

    bit          in_frame[2];
    bit          gap_act[2];
    int          ss_len[2];
    int          gap_cnt[2];
    int          mosi_err[2];
    int          stab_err[2];
    logic [95:0] last_rx[2];

    always #5 clk = ~clk;

    spi_frame_master #(
        .FRAME_W(16), .DIV(DIV16), .LEAD_CYC(LEAD), .TRAIL_CYC(TRAIL), .GAP_CYC(GAP)
    ) dut16 (
        .clk(clk), .rst(rst), .i_start(start16), .i_abort(abort16), .i_tx_data(tx16),
        .o_rx_data(rx16), .o_busy(busy16), .o_done(done16), .o_ss(ss16), .o_mosi(mosi16),
        .i_miso(miso16)
    );

    spi_frame_master #(
        .FRAME_W(96), .DIV(DIV96), .LEAD_CYC(LEAD), .TRAIL_CYC(TRAIL), .GAP_CYC(GAP)
    ) dut96 (
        .clk(clk), .rst(rst), .i_start(start96), .i_abort(abort96), .i_tx_data(tx96),
        .o_rx_data(rx96), .o_busy(busy96), .o_done(done96), .o_ss(ss96), .o_mosi(mosi96),
        .i_miso(miso96)
    );

    always @(posedge clk) begin
        cyc16   <= ss16 ? 0 : cyc16 + 1;
        mosi_d1 <= mosi16;
    end

    always_comb begin
        slave_bit16 = 1'b0;
        if (cyc16 >= LEAD && (cyc16 - LEAD) / DIV16 < 16)
            slave_bit16 = slave_pat16[15 - (cyc16 - LEAD) / DIV16];
    end

    assign miso16 = sel_slave16 ? slave_bit16 : mosi_d1;
    assign miso96 = mosi96;

    task automatic check(input bit ok, input string name, input logic [95:0] act,
                         input logic [95:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic exp_mosi(input int d, input logic [95:0] tx, input int c);
        int w, dv;
        w  = (d == 0) ? 16 : 96;
        dv = (d == 0) ? DIV16 : DIV96;
        if (c < LEAD) return tx[w-1];
        if (c < LEAD + w * dv) return tx[w - 1 - (c - LEAD) / dv];
        return 1'b0;
    endfunction

    task automatic mon_step(input int d, input logic ss, input logic mosi, input logic done,
                            input logic busy, input logic [95:0] rx);
        frame_t      f;
        bit          have;
        logic [95:0] exp_rx;
        if (rst) begin
            in_frame[d] = 1'b0;
            gap_act[d]  = 1'b0;
            stab_err[d] = 0;
            last_rx[d]  = '0;
            return;
        end
        if (d == 0) begin
            have = q0.size() > 0;
            if (have) f = q0[0];
        end else begin
            have = q1.size() > 0;
            if (have) f = q1[0];
        end
        if (!ss) begin
            if (!in_frame[d]) begin
                in_frame[d] = 1'b1;
                ss_len[d]   = 0;
                mosi_err[d] = 0;
                if (!have) check(1'b0, "unexpected_frame", 96'(d), 96'(0));
            end
            if (have && mosi !== exp_mosi(d, f.tx, ss_len[d])) mosi_err[d]++;
            if (done || rx !== last_rx[d]) stab_err[d]++;
            ss_len[d]++;
        end else if (in_frame[d]) begin
            in_frame[d] = 1'b0;
            if (have) begin
                if (d == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                exp_rx = f.aborted ? last_rx[d] : f.rx;
                check(ss_len[d] == f.len, "ss_low_len", 96'(ss_len[d]), 96'(f.len));
                check(mosi_err[d] == 0, "mosi_bits", 96'(mosi_err[d]), 96'(0));
                check(stab_err[d] == 0, "rx_stable_no_early_done", 96'(stab_err[d]), 96'(0));
                check(done == !f.aborted, "done_at_end", 96'(done), 96'(!f.aborted));
                check(rx === exp_rx, "rx_data", rx, exp_rx);
                last_rx[d] = exp_rx;
            end
            stab_err[d] = 0;
            gap_act[d]  = 1'b1;
            gap_cnt[d]  = 1;
        end else begin
            if (done) check(1'b0, "spurious_done", 96'(d), 96'(0));
            if (rx !== last_rx[d]) stab_err[d]++;
            if (gap_act[d]) begin
                if (busy && gap_cnt[d] < 64) begin
                    gap_cnt[d]++;
                end else begin
                    check(!busy && gap_cnt[d] == GAP, "busy_after_ss_rise",
                          96'(gap_cnt[d]), 96'(GAP));
                    gap_act[d] = 1'b0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0, ss16, mosi16, done16, busy16, {80'b0, rx16});
        mon_step(1, ss96, mosi96, done96, busy96, rx96);
    end

    task automatic drive(input int d, input bit st, input bit ab, input logic [95:0] tx);
        if (d == 0) begin
            start16 = st;
            abort16 = ab;
            if (st) tx16 = tx[15:0];
        end else begin
            start96 = st;
            abort96 = ab;
            if (st) tx96 = tx;
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        while (((d == 0) ? busy16 : busy96) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check(n < LIMIT, "idle_wait", 96'(n), 96'(LIMIT));
    endtask

    // start_at / abort_at are ss-low cycle indices (0 = first ss-low cycle), -1 = never.
    task automatic run_frame(input int d, input logic [95:0] tx, input logic [95:0] rx,
                             input int abort_at, input int start_at, input bit abort_with_start);
        frame_t f;
        int     len, c;
        len = LEAD + ((d == 0) ? 16 * DIV16 : 96 * DIV96) + TRAIL;
        wait_idle(d);
        f.tx      = tx;
        f.rx      = rx;
        f.aborted = (abort_at >= 0) && (abort_at < len);
        f.len     = f.aborted ? abort_at + 1 : len;
        if (d == 0) q0.push_back(f);
        else q1.push_back(f);
        drive(d, 1'b1, abort_with_start, tx);
        @(negedge clk);
        c = 0;
        while (((d == 0) ? busy16 : busy96) && c < LIMIT) begin
            drive(d, c == start_at, c == abort_at, ~tx);
            @(negedge clk);
            c++;
        end
        drive(d, 1'b0, 1'b0, tx);
        check(c < LIMIT, "frame_end", 96'(c), 96'(LIMIT));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [95:0] cnt, t;
        logic [7:0]  mask;
        logic [2:0]  k;
        int          ab;

        repeat (3) @(negedge clk);
        check(ss16 === 1'b1 && ss96 === 1'b1, "reset_ss", {ss16, ss96}, 2'b11);
        check(!busy16 && !busy96 && !done16 && !done96, "reset_busy_done",
              {busy16, busy96, done16, done96}, 0);
        check(!mosi16 && !mosi96, "reset_mosi", {mosi16, mosi96}, 0);
        check(rx16 === '0 && rx96 === '0, "reset_rx", rx96 | rx16, 0);
        rst = 1'b0;
        @(negedge clk);

        sel_slave16 = 1'b0;
        run_frame(0, 96'hA5C3, 96'hA5C3, -1, -1, 1'b0);

        sel_slave16 = 1'b1;
        slave_pat16 = 16'h3C81;
        run_frame(0, 96'h5A5A, 96'h3C81, -1, -1, 1'b0);

        sel_slave16 = 1'b0;
        run_frame(0, 96'h1E2D, 96'h1E2D, -1, LEAD + 8 * DIV16, 1'b0);
        repeat (10) @(negedge clk);
        check(!busy16 && ss16, "start_busy_ignored", {busy16, ss16}, 2'b01);

        t = {$urandom, $urandom, $urandom};
        run_frame(1, t, t, LEAD + 5 * DIV96, -1, 1'b0);

        for (int i = 0; i < 8; i++) cnt[12 * i +: 12] = 12'((i + 1) * 12'h111);
        run_frame(1, cnt, cnt, -1, -1, 1'b1);
        for (int i = 0; i < PW_COUNT; i++)
            check(rx96[pw_lsb(i) +: PW_W] == 12'((i + 1) * 12'h111), "pw_field",
                  96'(rx96[pw_lsb(i) +: PW_W]), 96'((i + 1) * 12'h111));

        mask = 8'($urandom);
        k    = 3'($urandom);
        run_frame(0, {85'b0, k, mask}, {85'b0, k, mask}, -1, -1, 1'b0);
        check(rx16[SW_MASK_LSB +: SW_MASK_W] == mask && rx16[K_LSB +: K_W] == k,
              "sw_k_fields", 96'(rx16), {85'b0, k, mask});

        // Asynchronous reset in the middle of the shift phase.
        wait_idle(0);
        q0.push_back('{tx: 96'hBEEF, rx: 96'hBEEF, len: 0, aborted: 1'b0});
        drive(0, 1'b1, 1'b0, 96'hBEEF);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 96'hBEEF);
        repeat (LEAD + 3 * DIV16 + 1) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check(ss16 === 1'b1 && busy16 === 1'b0, "async_reset_ss_busy", {ss16, busy16}, 2'b10);
        check(!mosi16 && !done16 && rx16 === '0, "async_reset_outputs", {mosi16, done16, rx16},
              0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        run_frame(0, 96'h7E81, 96'h7E81, -1, -1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            t           = 96'($urandom);
            sel_slave16 = $urandom_range(1, 0) == 1;
            slave_pat16 = 16'($urandom);
            ab          = ($urandom_range(2, 0) == 0) ? int'($urandom_range(71, 0)) : -1;
            run_frame(0, t, sel_slave16 ? {80'b0, slave_pat16} : {80'b0, t[15:0]}, ab, -1, 1'b0);
        end
        for (int i = 0; i < 6; i++) begin
            t  = {$urandom, $urandom, $urandom};
            ab = ($urandom_range(2, 0) == 0) ? int'($urandom_range(103, 0)) : -1;
            run_frame(1, t, t, ab, -1, 1'b0);
        end

        wait_idle(0);
        wait_idle(1);
        repeat (8) @(negedge clk);
        check(q0.size() == 0 && q1.size() == 0, "all_frames_seen", 96'(q0.size() + q1.size()),
              0);
        check(stab_err[0] == 0 && stab_err[1] == 0, "rx_stable_idle",
              96'(stab_err[0] + stab_err[1]), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
